// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin, packet-locked merge of N valid/ready input
// streams into one registered output stream. A requester keeps the grant
// from its first beat up to and including the beat flagged with last, so
// packets from different producers never interleave downstream.
module stream_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int GW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [GW-1:0]        out_grant,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   lastGrant_q, lastGrant_d;
  logic [WIDTH-1:0] outData_q;
  logic            outLast_q;
  logic [GW-1:0]   outGrant_q;
  logic            outValid_q;

  logic [GW-1:0]   pick;
  logic            pickFound;
  logic [GW:0]     cand;
  logic            accept;
  logic            inXfer;

  // The granted requester may move a beat whenever the output register is
  // empty or being drained this cycle; this never looks at in_valid.
  assign accept = (state_q == BUSY) && (!outValid_q || out_ready);
  assign inXfer = accept && in_valid[grant_q];

  // Round-robin search starting one past the last served requester, with
  // wrap-around; cand is one bit wider so the sum never overflows.
  always_comb begin
    pick      = lastGrant_q;
    pickFound = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, lastGrant_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(N)) begin
        cand = cand - (GW+1)'(N);
      end
      if (!pickFound && in_valid[cand[GW-1:0]]) begin
        pick      = cand[GW-1:0];
        pickFound = 1'b1;
      end
    end
  end

  // State register together with the grant bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      lastGrant_q <= GW'(N-1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  // Next state: arbitrate in IDLE, hold the grant until the last beat moves.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    case (state_q)
      IDLE: begin
        if (pickFound) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (inXfer && in_last[grant_q]) begin
          lastGrant_d = grant_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state: only the granted lane may see ready.
  always_comb begin
    in_ready = '0;
    busy     = 1'b0;
    if (state_q == BUSY) begin
      busy              = 1'b1;
      in_ready[grant_q] = accept;
    end
  end

  // Output register: load on input transfer, empty on a drain with no refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outData_q  <= '0;
      outLast_q  <= 1'b0;
      outGrant_q <= '0;
      outValid_q <= 1'b0;
    end else if (inXfer) begin
      outData_q  <= in_data[grant_q*WIDTH +: WIDTH];
      outLast_q  <= in_last[grant_q];
      outGrant_q <= grant_q;
      outValid_q <= 1'b1;
    end else if (outValid_q && out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign out_data  = outData_q;
  assign out_last  = outLast_q;
  assign out_grant = outGrant_q;
  assign out_valid = outValid_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter: directed, self-checking bench for stream_arbiter with
// hand-computed expectations and a small two-deep FIFO model downstream.
module tb_stream_arbiter;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int GW    = $clog2(N);

  logic               clk;
  logic               rst;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [GW-1:0]      out_grant;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifoQ[$];
  logic [7:0] popped[$];

  stream_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_grant (out_grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something upstream never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one requester lane.
  task automatic applyStimulus(input int lane, input logic [7:0] d, input logic l, input logic v);
    in_data[lane*WIDTH +: WIDTH] = d;
    in_last[lane]                = l;
    in_valid[lane]               = v;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with idle inputs, released on a falling edge.
  task automatic doReset();
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed sequence covering every scenario in order.
  initial begin
    logic [7:0] outD;
    logic       outX;
    logic       inX;
    int         beatIdx;
    logic       done;

    doReset();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_last",  out_last, 0);
    checkOutput("rst_out_data",  out_data, 0);
    checkOutput("rst_out_grant", out_grant, 0);
    checkOutput("rst_in_ready",  in_ready, 0);
    checkOutput("rst_busy",      busy, 0);

    // Single 3-beat packet from requester 2.
    applyStimulus(2, 8'h11, 1'b0, 1'b1);
    #1;
    checkOutput("sp_idle_ready", in_ready, 0);
    tick();
    checkOutput("sp_busy_rise", busy, 1);
    checkOutput("sp_ready", in_ready, 4'b0100);
    checkOutput("sp_no_out_yet", out_valid, 0);
    tick();
    checkOutput("sp_b1_data", out_data, 8'h11);
    checkOutput("sp_b1_valid", out_valid, 1);
    checkOutput("sp_b1_grant", out_grant, 2);
    checkOutput("sp_b1_last", out_last, 0);
    applyStimulus(2, 8'h22, 1'b0, 1'b1);
    tick();
    checkOutput("sp_b2_data", out_data, 8'h22);
    checkOutput("sp_b2_last", out_last, 0);
    applyStimulus(2, 8'h33, 1'b1, 1'b1);
    tick();
    checkOutput("sp_b3_data", out_data, 8'h33);
    checkOutput("sp_b3_last", out_last, 1);
    checkOutput("sp_b3_grant", out_grant, 2);
    checkOutput("sp_busy_fall", busy, 0);
    checkOutput("sp_idle_ready2", in_ready, 0);
    applyStimulus(2, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("sp_drained", out_valid, 0);

    // Round robin with all four offering single-beat packets.
    doReset();
    for (int i = 0; i < N; i++) applyStimulus(i, 8'hA0 + 8'(i), 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k > 0) checkOutput("rr_bubble", out_valid, 0);
      tick();
      checkOutput("rr_valid", out_valid, 1);
      checkOutput("rr_grant", out_grant, k % N);
      checkOutput("rr_data", out_data, 8'hA0 + 8'(k % N));
    end
    in_valid = '0;
    in_last  = '0;
    tick();

    // Packet lock: requester 1 holds the grant while requester 0 waits.
    applyStimulus(1, 8'h41, 1'b0, 1'b1);
    tick();
    checkOutput("pl_ready", in_ready, 4'b0010);
    tick();
    checkOutput("pl_b1", out_data, 8'h41);
    checkOutput("pl_b1_grant", out_grant, 1);
    applyStimulus(1, 8'h42, 1'b0, 1'b1);
    applyStimulus(0, 8'h50, 1'b1, 1'b1);
    #1;
    checkOutput("pl_lock_ready", in_ready, 4'b0010);
    tick();
    checkOutput("pl_b2", out_data, 8'h42);
    checkOutput("pl_lock_ready2", in_ready, 4'b0010);
    applyStimulus(1, 8'h43, 1'b0, 1'b1);
    tick();
    checkOutput("pl_b3", out_data, 8'h43);
    checkOutput("pl_b3_grant", out_grant, 1);
    applyStimulus(1, 8'h44, 1'b1, 1'b1);
    tick();
    checkOutput("pl_b4", out_data, 8'h44);
    checkOutput("pl_b4_last", out_last, 1);
    checkOutput("pl_b4_busy", busy, 0);
    applyStimulus(1, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("pl_next_busy", busy, 1);
    checkOutput("pl_next_ready", in_ready, 4'b0001);
    tick();
    checkOutput("pl_next_data", out_data, 8'h50);
    checkOutput("pl_next_grant", out_grant, 0);
    applyStimulus(0, 8'h00, 1'b0, 1'b0);
    tick();

    // Backpressure: out_ready low for five cycles mid-packet.
    applyStimulus(3, 8'h61, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("bp_b1", out_data, 8'h61);
    checkOutput("bp_b1_grant", out_grant, 3);
    applyStimulus(3, 8'h62, 1'b0, 1'b1);
    tick();
    checkOutput("bp_b2", out_data, 8'h62);
    applyStimulus(3, 8'h63, 1'b0, 1'b1);
    out_ready = 1'b0;
    #1;
    checkOutput("bp_ready_low", in_ready, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("bp_hold_data", out_data, 8'h62);
      checkOutput("bp_hold_valid", out_valid, 1);
      checkOutput("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", in_ready, 4'b1000);
    tick();
    checkOutput("bp_b3", out_data, 8'h63);
    checkOutput("bp_b3_valid", out_valid, 1);
    applyStimulus(3, 8'h64, 1'b1, 1'b1);
    tick();
    checkOutput("bp_b4", out_data, 8'h64);
    checkOutput("bp_b4_last", out_last, 1);
    applyStimulus(3, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("bp_drained", out_valid, 0);

    // Reset asserted between edges during beat 2 of a 4-beat packet.
    applyStimulus(1, 8'h71, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("mr_b1", out_data, 8'h71);
    applyStimulus(1, 8'h72, 1'b0, 1'b1);
    tick();
    checkOutput("mr_b2", out_data, 8'h72);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mr_out_valid", out_valid, 0);
    checkOutput("mr_in_ready", in_ready, 0);
    checkOutput("mr_busy", busy, 0);
    applyStimulus(0, 8'h80, 1'b1, 1'b1);
    applyStimulus(1, 8'h73, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("mr_first_ready", in_ready, 4'b0001);
    checkOutput("mr_no_replay", out_valid, 0);
    tick();
    checkOutput("mr_first_data", out_data, 8'h80);
    checkOutput("mr_first_grant", out_grant, 0);
    in_valid = '0;
    in_last  = '0;
    tick();
    tick();

    // FIFO integration: two-deep FIFO whose reader starts late.
    fifoQ.delete();
    popped.delete();
    beatIdx = 0;
    done    = 1'b0;
    applyStimulus(2, 8'h91, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      out_ready = (fifoQ.size() < 2);
      #1;
      if (cyc == 10) begin
        checkOutput("ff_stall_ready", in_ready, 0);
        checkOutput("ff_stall_data", out_data, 8'h93);
        checkOutput("ff_stall_valid", out_valid, 1);
      end
      outX = out_valid & out_ready;
      outD = out_data;
      inX  = in_valid[2] & in_ready[2];
      tick();
      if (cyc >= 12 && fifoQ.size() > 0) popped.push_back(fifoQ.pop_front());
      if (outX) fifoQ.push_back(outD);
      if (inX) begin
        beatIdx++;
        if (beatIdx == 4) applyStimulus(2, 8'h00, 1'b0, 1'b0);
        else applyStimulus(2, 8'h91 + 8'(beatIdx), beatIdx == 3, 1'b1);
      end
      if (popped.size() == 4) done = 1'b1;
    end
    checkOutput("ff_all_drained", popped.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < popped.size()) checkOutput("ff_order", popped[i], 8'h91 + 8'(i));
    end
    checkOutput("ff_end_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
